cut_response_compactor: RTL and testbench

- Sits directly downstream of a generated combinational benchmark circuit (CUT) with IN_W inputs and OUT_W outputs.
- Consumes one response vector per applied input pattern over a full exhaustive sweep of 2^IN_W patterns.
- Compacts the sweep into a SIG_W-bit MISR signature and compares it against a golden signature.
- Used to validate synthesized, balanced and original netlist variants against each other in hardware or simulation.

---
 rtl/cut_cmp_pkg.sv | 19 +
 rtl/cut_misr_step.sv | 27 ++
 rtl/cut_response_compactor.sv | 130 +++++++++++++
 tb/tb_cut_response_compactor.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cut_cmp_pkg.sv
// Shared types and constants for the CUT response compactor.
package cut_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } cmp_state_e;

    localparam int          DEF_SIG_W = 16;
    localparam logic [15:0] DEF_POLY  = 16'h1021;
    localparam logic [15:0] DEF_SEED  = 16'hFFFF;

    // Bits needed to count every response 1-bit over one exhaustive sweep.
    function automatic int ones_cnt_w(input int out_w, input int in_w);
        return $clog2(out_w * (32'sd1 <<< in_w) + 32'sd1);
    endfunction

endpackage

// File: rtl/cut_misr_step.sv
// One MISR step: shift, polynomial feedback from the outgoing MSB, fold in the response.
module cut_misr_step
    import cut_cmp_pkg::*;
#(
    parameter int               SIG_W = DEF_SIG_W,
    parameter int               OUT_W = 15,
    parameter logic [SIG_W-1:0] POLY  = DEF_POLY
) (
    input  logic [SIG_W-1:0] sig,
    input  logic [OUT_W-1:0] resp,
    output logic [SIG_W-1:0] next_sig
);

    logic [SIG_W-1:0] fb_s;

    // Next signature; the MSB leaves the register after selecting the feedback.
    always_comb begin
        fb_s = '0;
        if (sig[SIG_W-1]) begin
            fb_s = POLY;
        end else begin
            fb_s = '0;
        end
        next_sig = {sig[SIG_W-2:0], 1'b0} ^ fb_s ^ SIG_W'(resp);
    end

endmodule

// File: rtl/cut_response_compactor.sv
// Compacts one exhaustive CUT sweep into a MISR signature and checks it against a golden value.
// Optional response ones counter enabled by defining CUT_CMP_ONES_COUNT_EN.
module cut_response_compactor
    import cut_cmp_pkg::*;
#(
    parameter int               IN_W  = 4,
    parameter int               OUT_W = 15,
    parameter int               SIG_W = DEF_SIG_W,
    parameter logic [SIG_W-1:0] POLY  = DEF_POLY,
    parameter logic [SIG_W-1:0] SEED  = DEF_SEED,
    localparam int              CNT_W = ones_cnt_w(OUT_W, IN_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_pattern,
    input  logic [OUT_W-1:0] in_resp,
    input  logic [SIG_W-1:0] golden_sig,
    output logic [SIG_W-1:0] sig,
    output logic [IN_W:0]    pat_count,
    output logic             busy,
    output logic             done,
    output logic             match,
    output logic             err_order,
    output logic [CNT_W-1:0] ones_total
);

    localparam logic [IN_W:0] LAST_BEAT = {1'b0, {IN_W{1'b1}}};

    cmp_state_e       state_r;
    logic [SIG_W-1:0] next_sig_s;
    logic             xfer_s;

    cut_misr_step #(
        .SIG_W (SIG_W),
        .OUT_W (OUT_W),
        .POLY  (POLY)
    ) u_step (
        .sig      (sig),
        .resp     (in_resp),
        .next_sig (next_sig_s)
    );

    // A beat is consumed only while collecting with the handshake complete.
    always_comb begin
        xfer_s = (state_r == COLLECT) && in_valid && in_ready;
    end

    // Sweep sequencing with all status outputs held in registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            sig       <= SEED;
            pat_count <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            match     <= 1'b0;
            err_order <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        state_r   <= COLLECT;
                        sig       <= SEED;
                        pat_count <= '0;
                        err_order <= 1'b0;
                        match     <= 1'b0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (xfer_s) begin
                        sig       <= next_sig_s;
                        pat_count <= pat_count + {{IN_W{1'b0}}, 1'b1};
                        // Out-of-order beats are still compacted; only the flag records it.
                        if (in_pattern != pat_count[IN_W-1:0]) begin
                            err_order <= 1'b1;
                        end
                        if (pat_count == LAST_BEAT) begin
                            match    <= (next_sig_s == golden_sig);
                            state_r  <= DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            in_ready <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

`ifdef CUT_CMP_ONES_COUNT_EN
    logic [CNT_W-1:0] beat_ones_s;
    logic             load_s;

    // Popcount of the current response beat and the sweep-start condition.
    always_comb begin
        beat_ones_s = '0;
        for (int i = 0; i < OUT_W; i++) begin
            beat_ones_s = beat_ones_s + CNT_W'(in_resp[i]);
        end
        load_s = start && (state_r != COLLECT);
    end

    // Running total of response 1-bits for the current sweep.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ones_total <= '0;
        end else if (load_s) begin
            ones_total <= '0;
        end else if (xfer_s) begin
            ones_total <= ones_total + beat_ones_s;
        end
    end
`else
    assign ones_total = '0;
`endif

endmodule

// File: tb/tb_cut_response_compactor.sv
// Scoreboard bench for cut_response_compactor: directed sweeps, checked by a done-triggered monitor.
module tb_cut_response_compactor;

    localparam int CNT_W = 8;
`ifdef CUT_CMP_ONES_COUNT_EN
    localparam bit ONES_EN = 1'b1;
`else
    localparam bit ONES_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_pattern = 4'd0;
    logic [14:0] in_resp = 15'd0;
    logic [15:0] golden_sig = 16'd0;

    logic             in_ready, busy, done, match, err_order;
    logic [15:0]      sig;
    logic [4:0]       pat_count;
    logic [CNT_W-1:0] ones_total;

    logic             d2_in_ready, d2_busy, d2_done, d2_match, d2_err_order;
    logic [15:0]      d2_sig;
    logic [4:0]       d2_pat_count;
    logic [CNT_W-1:0] d2_ones_total;

    cut_response_compactor #(.SEED(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_pattern(in_pattern), .in_resp(in_resp), .golden_sig(golden_sig), .sig(sig),
        .pat_count(pat_count), .busy(busy), .done(done), .match(match),
        .err_order(err_order), .ones_total(ones_total)
    );

    cut_response_compactor dut_def (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(d2_in_ready),
        .in_pattern(in_pattern), .in_resp(in_resp), .golden_sig(golden_sig), .sig(d2_sig),
        .pat_count(d2_pat_count), .busy(d2_busy), .done(d2_done), .match(d2_match),
        .err_order(d2_err_order), .ones_total(d2_ones_total)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] sig;
        logic        match;
        logic        err;
        logic [4:0]  pc;
        logic [7:0]  ones;
    } exp_t;

    exp_t        sb[$];
    exp_t        m_exp;
    logic        prev_done = 1'b0;
    int          total = 0;
    int          bad = 0;
    logic [14:0] resp_tab[16];
    logic [3:0]  pat_tab[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] m_step(input logic [15:0] s, input logic [14:0] r);
        logic [15:0] t;
        t = {s[14:0], 1'b0};
        if (s[15]) t = t ^ 16'h1021;
        return t ^ {1'b0, r};
    endfunction

    function automatic logic [15:0] model_sig(input logic [15:0] seed, input int beats);
        logic [15:0] s;
        s = seed;
        for (int i = 0; i < beats; i++) s = m_step(s, resp_tab[i]);
        return s;
    endfunction

    // Monitor: every rising done consumes one expected result.
    always @(negedge clk) begin
        if (done && !prev_done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                m_exp = sb.pop_front();
                chk("sb_sig", 32'(sig), 32'(m_exp.sig));
                chk("sb_match", 32'(match), 32'(m_exp.match));
                chk("sb_err_order", 32'(err_order), 32'(m_exp.err));
                chk("sb_pat_count", 32'(pat_count), 32'(m_exp.pc));
                chk("sb_ones_total", 32'(ones_total), 32'(m_exp.ones));
            end
        end
        prev_done = done;
    end

    task automatic run_sweep(input logic [15:0] golden, input logic [15:0] exp_sig,
                             input bit exp_match, input bit gaps, input bit start_mid);
        exp_t e;
        int   ones;
        bit   err_exp;
        ones = 0;
        err_exp = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ones += $countones(resp_tab[i]);
            if (pat_tab[i] != 4'(i)) err_exp = 1'b1;
        end
        e.sig = exp_sig;
        e.match = exp_match;
        e.err = err_exp;
        e.pc = 5'd16;
        e.ones = ONES_EN ? 8'(ones) : 8'd0;
        sb.push_back(e);

        @(negedge clk);
        start = 1'b1;
        golden_sig = golden;
        @(negedge clk);
        start = 1'b0;
        chk("start_sig", 32'(sig), 32'h0000);
        chk("start_ready", 32'(in_ready), 32'd1);
        chk("start_pc", 32'(pat_count), 32'd0);
        chk("d2_start_sig", 32'(d2_sig), 32'hFFFF);

        err_exp = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (gaps) begin
                for (int g = 0; g < i % 3; g++) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                    chk("gap_hold_pc", 32'(pat_count), 32'(i));
                end
            end
            in_valid = 1'b1;
            in_pattern = pat_tab[i];
            in_resp = resp_tab[i];
            start = start_mid && (i == 8);
            @(negedge clk);
            start = 1'b0;
            if (pat_tab[i] != 4'(i)) err_exp = 1'b1;
            chk("err_beat", 32'(err_order), 32'(err_exp));
            chk("done_latency", 32'(done), 32'(i == 15));
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("done_hold", 32'(done), 32'd1);
        chk("ready_in_done", 32'(in_ready), 32'd0);
        chk("sig_hold", 32'(sig), 32'(exp_sig));
    endtask

    initial begin
        logic [15:0] ref_sig;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sig", 32'(sig), 32'h0000);
        chk("rst_pc", 32'(pat_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_match", 32'(match), 32'd0);
        chk("rst_err", 32'(err_order), 32'd0);
        chk("rst_ones", 32'(ones_total), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_d2_sig", 32'(d2_sig), 32'hFFFF);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", 32'(in_ready), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // Zero response sweep
        for (int i = 0; i < 16; i++) begin
            resp_tab[i] = 15'h0000;
            pat_tab[i] = 4'(i);
        end
        run_sweep(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("d2_zero_sig", 32'(d2_sig), 32'(model_sig(16'hFFFF, 16)));

        // Single-bit walk, matching then mismatching golden (restart from DONE)
        resp_tab[0] = 15'h0001;
        run_sweep(16'h8000, 16'h8000, 1'b1, 1'b0, 1'b0);
        run_sweep(16'h8001, 16'h8000, 1'b0, 1'b0, 1'b0);

        // Varied responses: gap-free, then with gaps and a stray start mid-sweep
        for (int i = 0; i < 16; i++) resp_tab[i] = 15'(i * 2909 + 4660);
        ref_sig = model_sig(16'h0000, 16);
        run_sweep(ref_sig, ref_sig, 1'b1, 1'b0, 1'b0);
        run_sweep(ref_sig, ref_sig, 1'b1, 1'b1, 1'b1);

        // All-ones responses
        for (int i = 0; i < 16; i++) resp_tab[i] = 15'h7FFF;
        ref_sig = model_sig(16'h0000, 16);
        run_sweep(ref_sig, ref_sig, 1'b1, 1'b0, 1'b0);

        // Order error: patterns 3 and 4 swapped
        for (int i = 0; i < 16; i++) resp_tab[i] = 15'h0000;
        pat_tab[3] = 4'd4;
        pat_tab[4] = 4'd3;
        run_sweep(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
        pat_tab[3] = 4'd3;
        pat_tab[4] = 4'd4;

        // Reset in the middle of a sweep
        for (int i = 0; i < 16; i++) resp_tab[i] = 15'(i * 2909 + 4660);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_pattern = pat_tab[i];
            in_resp = resp_tab[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("partial_pc", 32'(pat_count), 32'd7);
        chk("partial_sig", 32'(sig), 32'(model_sig(16'h0000, 7)));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_sig", 32'(sig), 32'h0000);
        chk("midrst_pc", 32'(pat_count), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_d2_sig", 32'(d2_sig), 32'hFFFF);
        ref_sig = model_sig(16'h0000, 16);
        run_sweep(ref_sig, ref_sig, 1'b1, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
